mac_tx_rmii: RTL and testbench
==============================

# mac_tx_rmii

RMII transmit MAC stage in the UDP/IP stack. It takes the byte-wide Ethernet frame stream from the ARP/UDP transmit mux, starting at the destination MAC address. It prepends preamble and SFD, pads short frames, appends the CRC32 FCS and enforces the inter-frame gap. It serialises the frame into 2-bit RMII dibits at one dibit per clock, so the upstream interface is paced by a ready handshake.

## Interface
Parameters:
- P_PAD_EN, 1: 1 = zero-pad frames shorter than P_MIN_LEN bytes (excluding FCS); 0 = no padding.
- P_MIN_LEN, 60: minimum frame length before FCS, in bytes, 11-bit.
- P_IFG_BYTES, 12: inter-frame gap, in byte times (4 clocks each).

Ports:
- i_clk  in  1  50 MHz RMII reference clock; the only clock.
- i_rst  in  1  reset, asynchronous, active-high.
- i_mac_tx_sop  in  1  first byte of frame, qualified by i_mac_tx_vld.
- i_mac_tx_eop  in  1  last byte of frame, qualified by i_mac_tx_vld.
- i_mac_tx_vld  in  1  byte valid; held with data until accepted.
- i_mac_tx_dat  in  8  frame byte.
- o_mac_tx_rdy  out  1  byte accepted this cycle when vld & rdy.
- o_tx_busy  out  1  high in every state except IDLE.
- o_tx_err  out  1  one-cycle pulse on underrun or sop-in-frame.
- o_rmii_tx_vld  out  1  RMII TX_EN.
- o_rmii_tx_dat  out  2  RMII TXD[1:0].

## Operation
- FSM states: IDLE, PRE, DATA, PAD, FCS, IFG. There is a 2-bit dibit counter (dc) and an 11-bit byte counter (bc).
- IDLE: on vld & sop, go to PRE with dc=0 and bc=0. The byte is not consumed. vld without sop in IDLE raises o_tx_err for one cycle and the byte is not accepted.
- PRE: sends 7 × 0x55 then 0xD5, 32 clocks total. rdy is high on the last clock (bc=7, dc=3), which fetches the first frame byte into the shift register.
- DATA: each byte is sent LSB dibit first (bits[1:0], [3:2], [5:4], [7:6]). rdy is high at dc=3 unless the current byte had eop.
  - On an eop byte: go to PAD if P_PAD_EN and bytes sent < P_MIN_LEN, else go to FCS.
  - The byte counter saturates at 2047.
- Underrun: rdy high and vld low in DATA. o_tx_err pulses, the FCS is sent bit-inverted so the frame is corrupted, and the FSM goes to FCS and then IFG.
- sop with an accepted byte in DATA: the byte is treated as data, o_tx_err pulses, and the sop is otherwise ignored.
- PAD: sends 0x00 bytes until the byte count reaches P_MIN_LEN. Pad bytes are included in the CRC.
- CRC: IEEE 802.3 CRC32, polynomial 0x04C11DB7 in reflected form, initial value 0xFFFFFFFF.
  - Updated 2 bits per clock over data and pad dibits only.
  - FCS = ~crc, sent LSB first, byte 0 = FCS[7:0].
- FCS: 16 clocks. Then IFG: P_IFG_BYTES × 4 clocks with TX_EN low. Then IDLE.
- A sop presented during FCS or IFG waits; it is not accepted early.

## Timing
- Reset (asynchronous, active-high): state=IDLE, counters and CRC cleared. All outputs 0: rdy, busy, err, tx_vld, tx_dat.
- Reset mid-frame: outputs drop to 0 immediately. The frame is truncated and no FCS is sent.
- All outputs are registered.
- o_rmii_tx_vld first rises 1 clock after vld & sop are sampled in IDLE. It stays high continuously through PRE, DATA, PAD and FCS. It falls on the clock after the last FCS dibit.
- Frame duration on the wire is 4 × (8 + max(N, min) + 4) clocks, where N is the number of payload bytes.
- First payload dibit appears 1 clock after the PRE fetch. Upstream sees rdy every 4th clock in DATA, so at most one byte is accepted per 4 clocks.
- o_tx_busy rises with the first preamble dibit and falls on entry to IDLE.

## Test plan
- Short frame, padding on: 42-byte frame of 0x00 with P_MIN_LEN=60. The wire carries 7×0x55, 0xD5, 60×0x00 and a valid FCS matching a software CRC model. TX_EN is high for 288 clocks, followed by 48 clocks of idle.
- CRC check value: P_PAD_EN=0, 9-byte frame "123456789" (0x31..0x39). FCS bytes on the wire are 0x26, 0x39, 0xF4, 0xCB.
- Back-to-back frames: second sop held asserted from the end of the first frame. The second preamble starts exactly 48 clocks after TX_EN falls, and rdy is never asserted during FCS or IFG.
- Underrun: drop vld for one rdy slot at byte 20 of a 100-byte frame. o_tx_err pulses once, the FCS is the inverted CRC, then IFG and IDLE follow.
- Upstream stall timing: hold vld high continuously. rdy pulses at a fixed 4-clock period through DATA, and the byte order on the wire matches the input.
- Reset at byte 30: assert i_rst mid-frame. Outputs go to 0 asynchronously. After release, a new frame transmits correctly with a fresh CRC.

Source files
------------

// File: rtl/mac_tx_rmii.sv
// mac_tx_rmii: RMII TX MAC (preamble/SFD, pad, CRC32 FCS, IFG); byte stream in i_mac_tx_* / o_mac_tx_rdy, dibits out o_rmii_tx_*, status o_tx_busy/o_tx_err
module mac_tx_rmii #(
  parameter bit P_PAD_EN    = 1'b1,
  parameter int P_MIN_LEN   = 60,
  parameter int P_IFG_BYTES = 12
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_mac_tx_sop,
  input  logic       i_mac_tx_eop,
  input  logic       i_mac_tx_vld,
  input  logic [7:0] i_mac_tx_dat,
  output logic       o_mac_tx_rdy,
  output logic       o_tx_busy,
  output logic       o_tx_err,
  output logic       o_rmii_tx_vld,
  output logic [1:0] o_rmii_tx_dat
);
  typedef enum logic [2:0] {IDLE, PRE, DATA, PAD, FCS, IFG} state_t;
  state_t      state_q, state_d;
  logic [1:0]  dc_q, dc_d, txd_q, txd_d;
  logic [10:0] bc_q, bc_d, bc_sat;
  logic [11:0] bc_inc;
  logic [31:0] crc_q, crc_d, fcs;
  logic [7:0]  dat_q, dat_d, cur;
  logic        eop_q, eop_d, bad_q, bad_d, pad;
  logic        rdy_q, rdy_d, busy_q, busy_d, err_q, err_d, txv_q, txv_d;
  function automatic logic [31:0] crc2(input logic [31:0] c, input logic [1:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 2; i++) r = (r >> 1) ^ ((r[0] ^ d[i]) ? 32'hEDB88320 : 32'h0);
    return r;
  endfunction
  always_comb begin
    bc_inc  = {1'b0, bc_q} + 12'd1;
    bc_sat  = (&bc_q) ? bc_q : bc_inc[10:0];
    pad     = 1'b0;
    state_d = state_q;
    dc_d    = state_q == IDLE ? 2'd0 : dc_q + 2'd1;
    bc_d    = bc_q;
    dat_d   = dat_q;
    eop_d   = eop_q;
    bad_d   = bad_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: if (i_mac_tx_vld) begin
        state_d = i_mac_tx_sop ? PRE : IDLE;
        err_d   = !i_mac_tx_sop;
        bc_d    = '0;
      end
      PRE: if (dc_q == 2'd3) begin
        if (bc_q == 11'd7) begin
          bc_d    = '0;
          state_d = i_mac_tx_vld ? DATA : FCS;
          bad_d   = !i_mac_tx_vld;
          err_d   = !i_mac_tx_vld;
          dat_d   = i_mac_tx_dat;
          eop_d   = i_mac_tx_eop;
        end else bc_d = bc_sat;
      end
      DATA: if (dc_q == 2'd3) begin
        if (eop_q) begin
          pad     = P_PAD_EN && bc_inc < 12'(P_MIN_LEN);
          state_d = pad ? PAD : FCS;
          bc_d    = pad ? bc_sat : '0;
        end else if (i_mac_tx_vld) begin
          dat_d = i_mac_tx_dat;
          eop_d = i_mac_tx_eop;
          err_d = i_mac_tx_sop;
          bc_d  = bc_sat;
        end else begin
          state_d = FCS;
          bad_d   = 1'b1;
          err_d   = 1'b1;
          bc_d    = '0;
        end
      end
      PAD: if (dc_q == 2'd3) begin
        pad     = bc_inc < 12'(P_MIN_LEN);
        state_d = pad ? PAD : FCS;
        bc_d    = pad ? bc_sat : '0;
      end
      FCS: if (dc_q == 2'd3) begin
        state_d = bc_q == 11'd3 ? IFG : FCS;
        bc_d    = bc_q == 11'd3 ? '0 : bc_sat;
      end
      IFG: if (dc_q == 2'd3) begin
        if (bc_q == 11'(P_IFG_BYTES - 1)) begin
          state_d = i_mac_tx_vld && i_mac_tx_sop ? PRE : IDLE;
          bc_d    = '0;
        end else bc_d = bc_sat;
      end
      default: state_d = IDLE;
    endcase
    bad_d  = state_d == PRE ? 1'b0 : bad_d;
    // an underrun leaves the CRC uninverted on the wire so the receiver rejects the frame
    fcs    = bad_d ? crc_q : ~crc_q;
    cur    = state_d == PRE  ? (bc_d == 11'd7 ? 8'hD5 : 8'h55) :
             state_d == DATA ? dat_d :
             state_d == FCS  ? 8'(fcs >> {bc_d[1:0], 3'b000}) : 8'h00;
    txd_d  = 2'(cur >> {dc_d, 1'b0});
    crc_d  = state_d == PRE ? '1 : (state_d == DATA || state_d == PAD) ? crc2(crc_q, txd_d) : crc_q;
    txv_d  = state_d inside {PRE, DATA, PAD, FCS};
    busy_d = state_d != IDLE;
    rdy_d  = dc_d == 2'd3 && ((state_d == PRE && bc_d == 11'd7) || (state_d == DATA && !eop_d));
  end
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      state_q <= IDLE;
      dc_q    <= '0;
      bc_q    <= '0;
      crc_q   <= '0;
      dat_q   <= '0;
      eop_q   <= 1'b0;
      bad_q   <= 1'b0;
      rdy_q   <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      txv_q   <= 1'b0;
      txd_q   <= '0;
    end else begin
      state_q <= state_d;
      dc_q    <= dc_d;
      bc_q    <= bc_d;
      crc_q   <= crc_d;
      dat_q   <= dat_d;
      eop_q   <= eop_d;
      bad_q   <= bad_d;
      rdy_q   <= rdy_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      txv_q   <= txv_d;
      txd_q   <= txd_d;
    end
  assign o_mac_tx_rdy  = rdy_q;
  assign o_tx_busy     = busy_q;
  assign o_tx_err      = err_q;
  assign o_rmii_tx_vld = txv_q;
  assign o_rmii_tx_dat = txd_q;
endmodule

// File: tb/tb_mac_tx_rmii.sv
// tb_mac_tx_rmii: directed frame vectors and corner sequences for mac_tx_rmii
module tb_mac_tx_rmii;
  logic clk = 1'b0, rst = 1'b1;
  logic sop = 1'b0, eop = 1'b0, vld = 1'b0;
  logic [7:0] dat = 8'h00;
  logic rdy, busy, err, txv, rdy_n, busy_n, err_n, txv_n;
  logic [1:0] txd, txd_n;
  always #10 clk = ~clk;
  mac_tx_rmii dut (
    .i_clk(clk), .i_rst(rst), .i_mac_tx_sop(sop), .i_mac_tx_eop(eop), .i_mac_tx_vld(vld),
    .i_mac_tx_dat(dat), .o_mac_tx_rdy(rdy), .o_tx_busy(busy), .o_tx_err(err),
    .o_rmii_tx_vld(txv), .o_rmii_tx_dat(txd)
  );
  mac_tx_rmii #(.P_PAD_EN(1'b0)) dut_np (
    .i_clk(clk), .i_rst(rst), .i_mac_tx_sop(sop), .i_mac_tx_eop(eop), .i_mac_tx_vld(vld),
    .i_mac_tx_dat(dat), .o_mac_tx_rdy(rdy_n), .o_tx_busy(busy_n), .o_tx_err(err_n),
    .o_rmii_tx_vld(txv_n), .o_rmii_tx_dat(txd_n)
  );
  typedef struct packed {logic en; logic [1:0] d; logic rdy; logic err; logic busy;} smp_t;
  typedef struct {int n; logic [7:0] base; logic [7:0] step; int len_pad; int len_np;} vec_t;
  smp_t tr[$], trn[$];
  logic [9:0] src[$];
  vec_t vt[6];
  int n_cmp = 0, n_bad = 0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic int tlen(input bit np);
    return np ? trn.size() : tr.size();
  endfunction
  function automatic smp_t smp(input bit np, input int i);
    if (i < 0 || i >= tlen(np)) return '0;
    return np ? trn[i] : tr[i];
  endfunction
  function automatic int find_en(input bit np, input int from);
    smp_t x;
    for (int i = from; i < tlen(np); i++) begin
      x = smp(np, i);
      if (x.en) return i;
    end
    return -1;
  endfunction
  function automatic logic [7:0] wbyte(input bit np, input int s, input int k);
    logic [7:0] b;
    smp_t x;
    for (int j = 0; j < 4; j++) begin
      x = smp(np, s + 4 * k + j);
      b[2*j +: 2] = x.d;
    end
    return b;
  endfunction
  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int j = 0; j < 8; j++) r = r[0] ? (r >> 1) ^ 32'hEDB88320 : (r >> 1);
    return r;
  endfunction
  task automatic make_frame(input int n, input logic [7:0] base, input logic [7:0] step);
    for (int i = 0; i < n; i++) src.push_back({i == 0, i == n - 1, 8'(base + step * 8'(i))});
  endtask
  // drives src with vld held whenever data remains; drop_at withholds one rdy slot, rst_at stops after that many accepts
  task automatic run(input int drop_at, input int rst_at, output bit timeout);
    int idx = 0, cyc = 0;
    bit pend = 0, aborted = 0;
    tr.delete();
    trn.delete();
    timeout = 0;
    forever begin
      @(negedge clk);
      if (pend) idx++;
      if (rst_at >= 0 && idx == rst_at) return;
      tr.push_back({txv, txd, rdy, err, busy});
      trn.push_back({txv_n, txd_n, rdy_n, err_n, busy_n});
      if (!aborted && idx == drop_at && rdy) aborted = 1;
      vld = !aborted && idx < src.size();
      {sop, eop, dat} = vld ? src[idx] : 10'h0;
      pend = vld && rdy;
      if (!vld && !busy && !busy_n && cyc > 2) break;
      if (++cyc > 6000) begin
        timeout = 1;
        break;
      end
    end
  endtask
  task automatic check_frame(input string tag, input bit np, input int from, input int off, input int n,
                             input int min_len, input bit inv, input int exp_len, input int exp_rdy,
                             input int exp_err, output int s_nxt, output logic [31:0] fcs);
    int s, len, nb, gap, rdy_cnt, err_cnt, bad_pre, bad_pay, bad_iv, tail_rdy, last;
    logic [31:0] c;
    logic [7:0] b;
    smp_t x;
    s = find_en(np, from);
    len = 0;
    x = smp(np, s);
    while (x.en) begin
      len++;
      x = smp(np, s + len);
    end
    gap = 0;
    while (x.busy && !x.en) begin
      gap++;
      x = smp(np, s + len + gap);
    end
    nb = n < min_len ? min_len : n;
    c = '1;
    bad_pre = 0;
    bad_pay = 0;
    for (int k = 0; k < 8; k++) if (wbyte(np, s, k) !== (k == 7 ? 8'hD5 : 8'h55)) bad_pre++;
    for (int k = 0; k < nb; k++) begin
      b = k < n ? src[off + k][7:0] : 8'h00;
      if (wbyte(np, s, 8 + k) !== b) bad_pay++;
      c = crc_upd(c, b);
    end
    fcs = {wbyte(np, s, nb + 11), wbyte(np, s, nb + 10), wbyte(np, s, nb + 9), wbyte(np, s, nb + 8)};
    rdy_cnt = 0;
    err_cnt = 0;
    bad_iv = 0;
    tail_rdy = 0;
    last = -1;
    for (int i = s; i < s + len + gap; i++) begin
      x = smp(np, i);
      if (x.rdy) begin
        if (last >= 0 && i - last != 4) bad_iv++;
        if (i >= s + len - 16) tail_rdy++;
        last = i;
        rdy_cnt++;
      end
      if (x.err) err_cnt++;
    end
    check({tag, " en_len"}, len, exp_len);
    check({tag, " preamble_bad_bytes"}, bad_pre, 0);
    check({tag, " payload_bad_bytes"}, bad_pay, 0);
    check({tag, " fcs"}, fcs, inv ? c : ~c);
    check({tag, " ifg_len"}, gap, 48);
    check({tag, " rdy_count"}, rdy_cnt, exp_rdy);
    check({tag, " rdy_period_bad"}, bad_iv, 0);
    check({tag, " rdy_in_fcs_ifg"}, tail_rdy, 0);
    check({tag, " err_pulses"}, err_cnt, exp_err);
    s_nxt = s + len + gap;
  endtask
  initial begin
    bit to;
    int s2;
    logic [31:0] f;
    vt[0] = '{42, 8'h00, 8'h00, 288, 216};
    vt[1] = '{9,  8'h31, 8'h01, 288, 84};
    vt[2] = '{60, 8'h10, 8'h03, 288, 288};
    vt[3] = '{59, 8'hA5, 8'h01, 288, 284};
    vt[4] = '{61, 8'hFF, 8'hFF, 292, 292};
    vt[5] = '{1,  8'h5A, 8'h00, 288, 52};
    repeat (3) @(negedge clk);
    check("reset outputs", {rdy, busy, err, txv, txd}, 6'h0);
    check("reset outputs np", {rdy_n, busy_n, err_n, txv_n, txd_n}, 6'h0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    for (int v = 0; v < 6; v++) begin
      src.delete();
      make_frame(vt[v].n, vt[v].base, vt[v].step);
      run(-1, -1, to);
      check($sformatf("vec%0d timeout", v), to, 0);
      check_frame($sformatf("vec%0d pad", v), 0, 0, 0, vt[v].n, 60, 0, vt[v].len_pad, vt[v].n, 0, s2, f);
      check_frame($sformatf("vec%0d nopad", v), 1, 0, 0, vt[v].n, 0, 0, vt[v].len_np, vt[v].n, 0, s2, f);
      if (v == 1) check("crc check value", f, 32'hCBF43926);
    end
    vld = 1'b1;
    sop = 1'b0;
    dat = 8'hAA;
    @(negedge clk);
    check("idle no-sop err", err, 1);
    check("idle no-sop rdy", rdy, 0);
    vld = 1'b0;
    @(negedge clk);
    check("idle err one cycle", err, 0);
    check("idle stays idle", busy, 0);
    src.delete();
    make_frame(42, 8'h00, 8'h00);
    make_frame(10, 8'hC0, 8'h07);
    run(-1, -1, to);
    check("b2b timeout", to, 0);
    check_frame("b2b first", 0, 0, 0, 42, 60, 0, 288, 42, 0, s2, f);
    check("b2b restart on gap end", find_en(0, s2), s2);
    check_frame("b2b second", 0, s2, 42, 10, 60, 0, 288, 10, 0, s2, f);
    src.delete();
    make_frame(100, 8'h01, 8'h01);
    run(20, -1, to);
    check("underrun timeout", to, 0);
    check_frame("underrun", 0, 0, 0, 20, 0, 1, 128, 21, 1, s2, f);
    src.delete();
    make_frame(20, 8'h40, 8'h01);
    src[5][9] = 1'b1;
    run(-1, -1, to);
    check("sop in frame timeout", to, 0);
    check_frame("sop in frame", 0, 0, 0, 20, 60, 0, 288, 20, 1, s2, f);
    src.delete();
    make_frame(100, 8'h80, 8'h01);
    run(-1, 30, to);
    check("pre-reset tx_en", txv, 1);
    rst = 1'b1;
    #1;
    check("async reset outputs", {rdy, busy, err, txv, txd}, 6'h0);
    check("async reset outputs np", {rdy_n, busy_n, err_n, txv_n, txd_n}, 6'h0);
    vld = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    src.delete();
    make_frame(15, 8'h11, 8'h22);
    run(-1, -1, to);
    check("post reset timeout", to, 0);
    check_frame("post reset", 0, 0, 0, 15, 60, 0, 288, 15, 0, s2, f);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
